// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage issue bus between the decode stage and the scoreboard hazard unit.
// The decode stage drives the issue fields and reads back the front-end enables.
interface scoreboard_hazard_unit_if #(
    parameter int AW = 5,
    parameter int LW = 4
);
    logic          issue_valid;
    logic [AW-1:0] issue_rs;
    logic [AW-1:0] issue_rt;
    logic          issue_uses_rs;
    logic          issue_uses_rt;
    logic          issue_wr;
    logic [AW-1:0] issue_rd;
    logic [LW-1:0] issue_lat;
    logic          flush;
    logic          stall;
    logic          PC_write;
    logic          IFID_write;
    logic          bubble_idex;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
               issue_wr, issue_rd, issue_lat, flush,
        input  stall, PC_write, IFID_write, bubble_idex
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_uses_rs, issue_uses_rt,
               issue_wr, issue_rd, issue_lat, flush,
        output stall, PC_write, IFID_write, bubble_idex
    );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Countdown scoreboard that holds the ID instruction until its sources can be forwarded into EX.
// Optional WAW ordering check: define SCB_WAW_CHECK_EN.
module scoreboard_hazard_unit #(
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 8,
    parameter int LW      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    scoreboard_hazard_unit_if.slave   id,
    output logic [NREGS-1:0]          pending,
    output logic [31:0]               stall_cycles
);

    logic [LW-1:0] cnt [NREGS];
    logic [LW-1:0] eff_lat;
    logic [LW-1:0] new_cnt;
    logic          raw_hazard;
    logic          waw_hazard;
    logic          stall_int;
    logic          issue_fire;

    // A latency of 0 means "forwardable next cycle", same as an ALU op.
    always_comb begin
        eff_lat = id.issue_lat;
        if (id.issue_lat == '0) begin
            eff_lat = LW'(1);
        end else if (id.issue_lat > LW'(MAX_LAT)) begin
            eff_lat = LW'(MAX_LAT);
        end
        new_cnt = eff_lat - LW'(1);
    end

    always_comb begin
        raw_hazard = (id.issue_uses_rs && (cnt[id.issue_rs] != '0)) ||
                     (id.issue_uses_rt && (cnt[id.issue_rt] != '0));
`ifdef SCB_WAW_CHECK_EN
        // Keep a short op from retiring its result before an older long op to the same rd.
        waw_hazard = id.issue_wr && (id.issue_rd != '0) && (cnt[id.issue_rd] > new_cnt);
`else
        waw_hazard = 1'b0;
`endif
        stall_int  = id.issue_valid && !id.flush && (raw_hazard || waw_hazard);
        issue_fire = id.issue_valid && !id.flush && !stall_int;
    end

    assign id.stall       = stall_int;
    assign id.PC_write    = !stall_int;
    assign id.IFID_write  = !stall_int;
    assign id.bubble_idex = stall_int || id.flush;

    // A new issue to rd replaces that register's countdown instead of decrementing it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == 0) begin
                    cnt[r] <= '0;
                end else if (issue_fire && id.issue_wr && (id.issue_rd == AW'(r))) begin
                    cnt[r] <= new_cnt;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall_int && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed-vector bench for scoreboard_hazard_unit (default build, no WAW check).
module tb_scoreboard_hazard_unit;

    localparam int NREGS   = 32;
    localparam int AW      = 5;
    localparam int MAX_LAT = 8;
    localparam int LW      = 4;

    logic              clock;
    logic              reset;
    logic [NREGS-1:0]  pending;
    logic [31:0]       stall_cycles;
    int                checks;
    int                errors;

    scoreboard_hazard_unit_if #(.AW(AW), .LW(LW)) sif ();

    scoreboard_hazard_unit #(
        .NREGS(NREGS), .AW(AW), .MAX_LAT(MAX_LAT), .LW(LW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .id          (sif),
        .pending     (pending),
        .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic urs, input logic urt, input logic wr,
                                 input logic [AW-1:0] rd, input logic [LW-1:0] lat, input logic fl);
        sif.issue_valid   = valid;
        sif.issue_rs      = rs;
        sif.issue_rt      = rt;
        sif.issue_uses_rs = urs;
        sif.issue_uses_rt = urt;
        sif.issue_wr      = wr;
        sif.issue_rd      = rd;
        sif.issue_lat     = lat;
        sif.flush         = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle();
        sif.flush = 1'b1;
        repeat (2) cycle();

        // Reset state
        checkOutput("rst_stall", 32'(sif.stall), 32'd0);
        checkOutput("rst_pcw", 32'(sif.PC_write), 32'd1);
        checkOutput("rst_ifidw", 32'(sif.IFID_write), 32'd1);
        checkOutput("rst_bubble_eq_flush", 32'(sif.bubble_idex), 32'd1);
        checkOutput("rst_pending", pending, 32'd0);
        checkOutput("rst_stallcnt", stall_cycles, 32'd0);
        reset = 1'b1;
        idle();
        cycle();

        // Test 1: async reset mid-stream with cnt[5]=3
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 4'd4, 1'b0);
        cycle();
        checkOutput("t1_pend5", 32'(pending[5]), 32'd1);
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0);
        #1;
        checkOutput("t1_stall_before_rst", 32'(sif.stall), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("t1_rst_stall", 32'(sif.stall), 32'd0);
        checkOutput("t1_rst_pending", pending, 32'd0);
        checkOutput("t1_rst_pcw", 32'(sif.PC_write), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("t1_read5_nostall", 32'(sif.stall), 32'd0);
        cycle();
        checkOutput("t1_stallcnt", stall_cycles, 32'd0);

        // Test 2: load-use gives exactly one stall cycle
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 4'd2, 1'b0);
        cycle();
        applyStimulus(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 4'd1, 1'b0);
        @(negedge clock);
        checkOutput("t2_stall", 32'(sif.stall), 32'd1);
        checkOutput("t2_pcw", 32'(sif.PC_write), 32'd0);
        checkOutput("t2_ifidw", 32'(sif.IFID_write), 32'd0);
        checkOutput("t2_bubble", 32'(sif.bubble_idex), 32'd1);
        cycle();
        checkOutput("t2_stallcnt", stall_cycles, 32'd1);
        checkOutput("t2_stall_released", 32'(sif.stall), 32'd0);
        checkOutput("t2_bubble_released", 32'(sif.bubble_idex), 32'd0);
        cycle();
        checkOutput("t2_pend9", 32'(pending[9]), 32'd0);

        // Test 3: mul lat=6 -> five stall cycles on r3
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 4'd6, 1'b0);
        cycle();
        applyStimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 4'd1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput($sformatf("t3_stall_%0d", i), 32'(sif.stall), (i < 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_pend3_%0d", i), 32'(pending[3]), (i < 5) ? 32'd1 : 32'd0);
            cycle();
        end
        checkOutput("t3_stallcnt", stall_cycles, 32'd6);

        // Test 4: ALU chain r1->r2->r3 never stalls; r0 and latency clamping
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 4'd1, 1'b0);
        #1 checkOutput("t4_i1_stall", 32'(sif.stall), 32'd0);
        cycle();
        applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 4'd1, 1'b0);
        #1 checkOutput("t4_i2_stall", 32'(sif.stall), 32'd0);
        cycle();
        applyStimulus(1'b1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 4'd1, 1'b0);
        #1 checkOutput("t4_i3_stall", 32'(sif.stall), 32'd0);
        cycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 4'd8, 1'b0);
        cycle();
        checkOutput("t4_pend0", 32'(pending[0]), 32'd0);
        checkOutput("t4_pending_all", pending, 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 4'd0, 1'b0);
        cycle();
        checkOutput("t4_lat0_pend10", 32'(pending[10]), 32'd0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 4'd15, 1'b0);
        cycle();
        idle();
        repeat (6) cycle();
        checkOutput("t4_clamp_pend11_hi", 32'(pending[11]), 32'd1);
        cycle();
        checkOutput("t4_clamp_pend11_lo", 32'(pending[11]), 32'd0);

        // Test 5: flush overrides stall and never records
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 4'd3, 1'b0);
        cycle();
        applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 4'd5, 1'b1);
        @(negedge clock);
        checkOutput("t5_flush_stall", 32'(sif.stall), 32'd0);
        checkOutput("t5_flush_bubble", 32'(sif.bubble_idex), 32'd1);
        checkOutput("t5_flush_pcw", 32'(sif.PC_write), 32'd1);
        cycle();
        checkOutput("t5_pend12", 32'(pending[12]), 32'd0);
        checkOutput("t5_pend4", 32'(pending[4]), 32'd1);
        checkOutput("t5_stallcnt", stall_cycles, 32'd6);
        applyStimulus(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 4'd5, 1'b0);
        @(negedge clock);
        checkOutput("t5_unflushed_stall", 32'(sif.stall), 32'd1);
        cycle();
        checkOutput("t5_stallcnt2", stall_cycles, 32'd7);
        checkOutput("t5_release", 32'(sif.stall), 32'd0);
        cycle();
        checkOutput("t5_pend12_issued", 32'(pending[12]), 32'd1);
        idle();
        repeat (4) cycle();

`ifndef SCB_WAW_CHECK_EN
        // Test 6: without WAW check a short op simply overwrites a long one
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 4'd8, 1'b0);
        cycle();
        checkOutput("t6_pend7_div", 32'(pending[7]), 32'd1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 4'd1, 1'b0);
        #1 checkOutput("t6_add_stall", 32'(sif.stall), 32'd0);
        cycle();
        checkOutput("t6_pend7_add", 32'(pending[7]), 32'd0);
        idle();
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
